// File: rtl/fetch_pkg.sv
// Shared fetch types: FSM states, PC step, queue entry layout, PC alignment helper.
// No timing or backpressure of its own; latency and stalling belong to the users.
package fetch_pkg;

    localparam logic [31:0] PC_INC = 32'd4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        STALL = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/inst_fetch_ctrl_if.sv
// Fetched-instruction output channel (valid/ready); the producer drives valid/inst/pc.
// No latency of its own; out_rdy=0 holds the head entry on the channel.
interface inst_fetch_ctrl_if;
    logic        out_vld;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic        out_rdy;

    modport master (output out_vld, out_inst, out_pc, input out_rdy);
    modport slave  (input out_vld, out_inst, out_pc, output out_rdy);
endinterface

// File: rtl/fetch_queue.sv
// Two-entry fetch queue with flush; a push is visible on the output one cycle later.
// Caller must not push when full unless popping in the same cycle; flush beats push/pop.
module fetch_queue
    import fetch_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  fetch_entry_t      push_dat,
    input  logic              flush,
    output logic              full,
    output logic              empty,
    inst_fetch_ctrl_if.master out_if
);

    fetch_entry_t [1:0] mem_q, mem_d;
    logic               rd_ptr_q, rd_ptr_d;
    logic               wr_ptr_q, wr_ptr_d;
    logic [1:0]         cnt_q, cnt_d;
    logic               pop;

    assign full            = (cnt_q == 2'd2);
    assign empty           = (cnt_q == 2'd0);
    assign pop             = out_if.out_vld & out_if.out_rdy;
    assign out_if.out_vld  = !empty;
    assign out_if.out_inst = mem_q[rd_ptr_q].inst;
    assign out_if.out_pc   = mem_q[rd_ptr_q].pc;

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;
        if (flush) begin
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
            cnt_d    = 2'd0;
        end else begin
            // When full, the slot being written is the one being popped this cycle.
            if (push) begin
                mem_d[wr_ptr_q] = push_dat;
                wr_ptr_d        = ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q    <= '0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/inst_fetch_ctrl.sv
// Sequential instruction fetcher feeding a 2-deep queue; words appear 1 cycle after fetch.
// Stalls (imem_ce=0) when the queue is full and not popping; FETCH_ALIGN_CHECK_EN traps misaligned redirects.
module inst_fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    output logic        imem_ce,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc,
    input  logic        out_ready,
    output logic        align_err
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         push, pop, q_full, q_empty, redir_bad;
    fetch_entry_t push_dat;

    inst_fetch_ctrl_if q_if ();

    assign q_if.out_rdy = out_ready;
    assign out_valid    = q_if.out_vld;
    assign out_inst     = q_if.out_inst;
    assign out_pc       = q_if.out_pc;
    assign pop          = !q_empty & out_ready;
    assign imem_addr    = pc_q;
    assign push_dat     = '{pc: pc_q, inst: imem_data};

`ifdef FETCH_ALIGN_CHECK_EN
    logic align_err_q, align_err_d;

    assign redir_bad = redirect_valid & (redirect_pc[1:0] != 2'b00);
    assign align_err = align_err_q;

    always_comb begin
        align_err_d = align_err_q;
        if (redirect_valid) begin
            align_err_d = redir_bad;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            align_err_q <= 1'b0;
        end else begin
            align_err_q <= align_err_d;
        end
    end
`else
    assign redir_bad = 1'b0;
    assign align_err = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        imem_ce = 1'b0;
        push    = 1'b0;
        case (state_q)
            IDLE: begin
                if (en && !align_err) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                imem_ce = !(q_full && !pop);
                push    = imem_ce && !redirect_valid;
                if (push) begin
                    pc_d = pc_q + PC_INC;
                end
                if (!imem_ce) begin
                    state_d = STALL;
                end
            end
            STALL: begin
                if (pop) begin
                    state_d = FETCH;
                end
            end
            default: state_d = IDLE;
        endcase
        if (!en) begin
            state_d = IDLE;
        end
        // A redirect overrides everything above; the queue flush happens in fetch_queue.
        if (redirect_valid) begin
            if (redir_bad) begin
                pc_d    = pc_q;
                state_d = IDLE;
            end else begin
                pc_d    = word_align(redirect_pc);
                state_d = en ? FETCH : IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    fetch_queue u_queue (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .push_dat (push_dat),
        .flush    (redirect_valid),
        .full     (q_full),
        .empty    (q_empty),
        .out_if   (q_if.master)
    );

endmodule
